// File: rtl/keypad_debounce_encoder.sv
// Ten-key digit keypad front end: synchronizes raw key lines, debounces one-hot
// presses and releases against an external tick, and reports the digit as BCD.
module keypad_debounce_encoder #(
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [9:0] keys,
  output logic [3:0] bcd,
  output logic       valid,
  output logic       held,
  output logic       multi_key
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(DEB_TICKS - 1);

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] encode(input logic [9:0] v);
    logic [3:0] idx;
    case (v)
      10'b00_0000_0001: idx = 4'd0;
      10'b00_0000_0010: idx = 4'd1;
      10'b00_0000_0100: idx = 4'd2;
      10'b00_0000_1000: idx = 4'd3;
      10'b00_0001_0000: idx = 4'd4;
      10'b00_0010_0000: idx = 4'd5;
      10'b00_0100_0000: idx = 4'd6;
      10'b00_1000_0000: idx = 4'd7;
      10'b01_0000_0000: idx = 4'd8;
      10'b10_0000_0000: idx = 4'd9;
      default:          idx = 4'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [9:0] decode(input logic [3:0] idx);
    return 10'd1 << idx;
  endfunction

  logic [9:0] sync1_q;
  logic [9:0] sync_q;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] bcd_q, bcd_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic       multi_q;
  logic       match_s;

  // Two-flop synchronizer on the raw key lines plus the informational multi-key flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 10'd0;
      sync_q  <= 10'd0;
      multi_q <= 1'b0;
    end else begin
      sync1_q <= keys;
      sync_q  <= sync1_q;
      multi_q <= ((sync_q & (sync_q - 10'd1)) != 10'd0);
    end
  end

  // Debounce FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
      bcd_q   <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign match_s = (sync_q == decode(cand_q));

  // Next-state logic; a pattern change always wins over a same-cycle tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        if (is_onehot(sync_q)) begin
          cand_d  = encode(sync_q);
          cnt_d   = 4'd0;
          state_d = DEBOUNCE;
        end else begin
          state_d = IDLE;
        end
      end
      DEBOUNCE: begin
        if (!match_s) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q == LAST_CNT) begin
            bcd_d   = cand_q;
            valid_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = 4'd0;
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = DEBOUNCE;
        end
      end
      PRESSED: begin
        if (sync_q == 10'd0) begin
          cnt_d   = 4'd0;
          state_d = RELEASE;
        end else begin
          state_d = PRESSED;
        end
      end
      RELEASE: begin
        if (sync_q != 10'd0) begin
          cnt_d   = 4'd0;
          state_d = PRESSED;
        end else if (tick) begin
          if (cnt_q == LAST_CNT) begin
            held_d  = 1'b0;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        held_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bcd       = bcd_q;
  assign valid     = valid_q;
  assign held      = held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder: a segment table for steady-state
// behaviour plus hand sequences for bounce, reset-mid-press and DEB_TICKS=1.
module tb_keypad_debounce_encoder;

  localparam int TICK_P = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [9:0] keys;
  logic [9:0] keys1;
  logic [3:0] bcd, bcd1;
  logic       valid, valid1;
  logic       held, held1;
  logic       multi_key, multi_key1;

  int n_cmp = 0;
  int n_bad = 0;
  int tcnt = 0;
  int ticks_seen = 0;
  int vcnt = 0;
  int vcnt1 = 0;

  keypad_debounce_encoder #(.DEB_TICKS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .keys(keys),
    .bcd(bcd), .valid(valid), .held(held), .multi_key(multi_key)
  );

  keypad_debounce_encoder #(.DEB_TICKS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .keys(keys1),
    .bcd(bcd1), .valid(valid1), .held(held1), .multi_key(multi_key1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] keys;
    int         cycles;
    int         exp_valids;
    int         exp_bcd;
    int         exp_held;
    int         exp_multi;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample just after the edge, then schedule tick for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (tick) ticks_seen++;
    if (valid) vcnt++;
    if (valid1) vcnt1++;
    tcnt = (tcnt == TICK_P - 1) ? 0 : tcnt + 1;
    tick = (tcnt == TICK_P - 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Park halfway between ticks so a new pattern settles well before the next tick.
  task automatic align();
    for (int i = 0; i < TICK_P && tcnt != TICK_P / 2; i++) step();
  endtask

  task automatic wait_valid(input bit second, input int budget, input string name);
    int n;
    n = 0;
    vcnt = 0;
    vcnt1 = 0;
    while (((second ? vcnt1 : vcnt) == 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_seen"}, (second ? vcnt1 : vcnt), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{10'h003, 1000, 0, 0, 0, 1};
    vecs[1]  = '{10'h000,  300, 0, 0, 0, 0};
    vecs[2]  = '{10'h008,  600, 1, 3, 1, 0};
    vecs[3]  = '{10'h000,  600, 0, 3, 0, 0};
    vecs[4]  = '{10'h080,  600, 1, 7, 1, 0};
    vecs[5]  = '{10'h084,  500, 0, 7, 1, 1};
    vecs[6]  = '{10'h000,  600, 0, 7, 0, 0};
    vecs[7]  = '{10'h010,  600, 1, 4, 1, 0};
    vecs[8]  = '{10'h000,  150, 0, 4, 1, 0};
    vecs[9]  = '{10'h010,   60, 0, 4, 1, 0};
    vecs[10] = '{10'h000,  600, 0, 4, 0, 0};

    rst_n = 1'b0;
    tick  = 1'b0;
    keys  = 10'h003;
    keys1 = 10'h000;
    run(5);
    chk("rst_bcd", bcd, 0);
    chk("rst_valid", valid, 0);
    chk("rst_held", held, 0);
    chk("rst_multi", multi_key, 0);
    chk("rst_bcd1", bcd1, 0);
    keys = 10'h000;
    run(2);
    rst_n = 1'b1;
    run(3);

    for (int v = 0; v < 11; v++) begin
      keys = vecs[v].keys;
      vcnt = 0;
      run(vecs[v].cycles);
      chk($sformatf("vec%0d_valids", v), vcnt, vecs[v].exp_valids);
      chk($sformatf("vec%0d_bcd", v), bcd, vecs[v].exp_bcd);
      chk($sformatf("vec%0d_held", v), held, vecs[v].exp_held);
      chk($sformatf("vec%0d_multi", v), multi_key, vecs[v].exp_multi);
    end

    // Bounce on key 5, ending on the released phase, then a clean hold.
    vcnt = 0;
    for (int s = 0; s < 10; s++) begin
      keys = (s % 2 == 0) ? 10'h020 : 10'h000;
      run(30);
    end
    chk("bounce_no_valid", vcnt, 0);
    align();
    keys = 10'h020;
    ticks_seen = 0;
    wait_valid(1'b0, 800, "bounce");
    chk("bounce_ticks", ticks_seen, 4);
    chk("bounce_bcd", bcd, 5);
    chk("bounce_held", held, 1);
    run(300);
    chk("bounce_single", vcnt, 1);
    keys = 10'h000;
    run(600);
    chk("bounce_release_held", held, 0);

    // Asynchronous reset two ticks into debouncing key 9.
    align();
    keys = 10'h200;
    ticks_seen = 0;
    vcnt = 0;
    for (int i = 0; i < 400 && ticks_seen < 2; i++) step();
    chk("rstmid_pre_ticks", ticks_seen, 2);
    chk("rstmid_pre_valid", vcnt, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_bcd", bcd, 0);
    chk("rstmid_held", held, 0);
    chk("rstmid_valid", valid, 0);
    chk("rstmid_multi", multi_key, 0);
    #2 rst_n = 1'b1;
    ticks_seen = 0;
    wait_valid(1'b0, 800, "rstmid_repress");
    chk("rstmid_ticks", ticks_seen, 4);
    chk("rstmid_bcd9", bcd, 9);
    chk("rstmid_held1", held, 1);
    keys = 10'h000;
    run(600);

    // Single-tick debounce instance: key 1 then key 0.
    align();
    keys1 = 10'h002;
    ticks_seen = 0;
    wait_valid(1'b1, 400, "deb1_k1");
    chk("deb1_k1_ticks", ticks_seen, 1);
    chk("deb1_k1_bcd", bcd1, 1);
    chk("deb1_k1_held", held1, 1);
    keys1 = 10'h000;
    run(300);
    chk("deb1_k1_release", held1, 0);
    align();
    keys1 = 10'h001;
    ticks_seen = 0;
    wait_valid(1'b1, 400, "deb1_k0");
    chk("deb1_k0_ticks", ticks_seen, 1);
    chk("deb1_k0_bcd", bcd1, 0);
    chk("deb1_k0_held", held1, 1);
    run(300);
    chk("deb1_k0_single", vcnt1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
